multicycle_control: RTL and testbench

//  Moore-style FSM sequencing a multi-cycle MIPS datapath: one shared memory (instr+data), IR/MDR/A/B/ALUOut regs.

---
 rtl/multicycle_control.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM that sequences a multi-cycle MIPS datapath.
// It uses one shared instruction/data memory and the IR, MDR, A, B and ALUOut registers.
// It decodes OP/Funct, drives every mux select and write enable, and stalls on MemReady.
//
// Ports
//   clk, reset       clock; synchronous active-high reset (state -> FETCH)
//   OP, Funct        IR[31:26], IR[5:0]
//   Zero             ALU zero flag (branch condition)
//   MemReady         memory completes the current access this cycle
//   PCWrite..RegDst  datapath enables and mux selects
//   State            current state code (debug)
//   Illegal          high while in HALT
//   CycleCount, RetireCount  perf counters, present only when MC_PERF_CNT_EN is defined
//
// Build option: define MC_PERF_CNT_EN to add the CycleCount/RetireCount perf counters.
// Instruction latency with MemReady=1: branch/j/jal/jr take 3 cycles,
// R-type/addi/ori/sw take 4 cycles, and lw takes 5 cycles.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold while MemReady=0.
module multicycle_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] MemtoReg,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [3:0] State,
    output logic       Illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] CycleCount,
    output logic [CNT_WIDTH-1:0] RetireCount
`endif
);

    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("multicycle_control: CNT_WIDTH must be at least 1");
    end

    typedef enum logic [3:0] {
        S_FETCH     = 4'h0,
        S_DECODE    = 4'h1,
        S_MEM_ADDR  = 4'h2,
        S_MEM_READ  = 4'h3,
        S_MEM_WB    = 4'h4,
        S_MEM_WRITE = 4'h5,
        S_EXECUTE   = 4'h6,
        S_ALU_WB    = 4'h7,
        S_BRANCH    = 4'h8,
        S_JUMP      = 4'h9,
        S_JR        = 4'hA,
        S_JAL       = 4'hB,
        S_IMM_EX    = 4'hC,
        S_IMM_WB    = 4'hD,
        S_HALT      = 4'hF
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_R   = 4'd7;

    // Mux select encodings
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;
    localparam logic [1:0] PCS_ALU     = 2'b00;
    localparam logic [1:0] PCS_ALUOUT  = 2'b01;
    localparam logic [1:0] PCS_JUMP    = 2'b10;
    localparam logic [1:0] PCS_REG_A   = 2'b11;
    localparam logic [1:0] M2R_ALUOUT  = 2'b00;
    localparam logic [1:0] M2R_MDR     = 2'b01;
    localparam logic [1:0] M2R_PC      = 2'b10;
    localparam logic [1:0] DST_RT      = 2'b00;
    localparam logic [1:0] DST_RD      = 2'b01;
    localparam logic [1:0] DST_RA      = 2'b10;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (MemReady) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (OP)
                    OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                    OP_RTYPE:        state_d = (Funct == FN_JR) ? S_JR : S_EXECUTE;
                    OP_ADDI, OP_ORI: state_d = S_IMM_EX;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_JAL:          state_d = S_JAL;
                    default:         state_d = S_HALT;
                endcase
            end
            // Only lw and sw reach MEM_ADDR, so one opcode compare is enough.
            S_MEM_ADDR:  state_d = (OP == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                if (MemReady) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: begin
                if (MemReady) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE:   state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_IMM_EX:    state_d = S_IMM_WB;
            S_IMM_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_JR:        state_d = S_FETCH;
            S_JAL:       state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            // The unused code 0xE can only come from corruption; park it in HALT.
            default:     state_d = S_HALT;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore, except the FETCH handshake and the branch condition)
    // ------------------------------------------------------------------
    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        MemtoReg = M2R_ALUOUT;
        PCSource = PCS_ALU;
        ALUOp    = ALU_ADD;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_B;
        RegWrite = 1'b0;
        RegDst   = DST_RT;
        Illegal  = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                // PC+4 is computed every cycle.
                // PC and IR commit only when the memory returns the word.
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: begin
                // Speculative branch target goes into ALUOut.
                ALUSrcB = SRCB_IMMSH;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_READ: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEM_WB: begin
                RegDst   = DST_RT;
                MemtoReg = M2R_MDR;
                RegWrite = 1'b1;
            end
            S_MEM_WRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_B;
                ALUOp   = ALU_R;
            end
            S_ALU_WB: begin
                RegDst   = DST_RD;
                MemtoReg = M2R_ALUOUT;
                RegWrite = 1'b1;
            end
            S_IMM_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = (OP == OP_ORI) ? ALU_OR : ALU_ADD;
            end
            S_IMM_WB: begin
                RegDst   = DST_RT;
                MemtoReg = M2R_ALUOUT;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_B;
                ALUOp    = ALU_SUB;
                PCSource = PCS_ALUOUT;
                PCWrite  = (OP == OP_BNE) ? ~Zero : Zero;
            end
            S_JUMP: begin
                PCSource = PCS_JUMP;
                PCWrite  = 1'b1;
            end
            S_JR: begin
                PCSource = PCS_REG_A;
                PCWrite  = 1'b1;
            end
            S_JAL: begin
                // PC still holds PC+4 here, so it is the link value written to $31.
                PCSource = PCS_JUMP;
                PCWrite  = 1'b1;
                RegDst   = DST_RA;
                MemtoReg = M2R_PC;
                RegWrite = 1'b1;
            end
            S_HALT: begin
                Illegal = 1'b1;
            end
            default: begin
                Illegal = 1'b1;
            end
        endcase

        // Reset kills every architectural side effect in the same cycle.
        // A half-finished instruction never writes the PC, the IR, the
        // register file or memory.
        if (reset) begin
            PCWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign State = state_q;

`ifdef MC_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (free-running, wrap at max, frozen in HALT)
    // ------------------------------------------------------------------
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        cycle_cnt_d  = cycle_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (state_q != S_HALT) begin
            cycle_cnt_d = cycle_cnt_q + CNT_ONE;
            // An instruction retires when the FSM returns to FETCH.
            if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
                retire_cnt_d = retire_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign CycleCount  = cycle_cnt_q;
    assign RetireCount = retire_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed literal checks plus randomized instruction
// streams compared every cycle against an instruction-level reference model
// that replays each opcode's state path from a lookup of its microsteps.
module tb_multicycle_control;
    localparam int CW = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] OP = 6'h00;
    logic [5:0] Funct = 6'h20;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b1;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] MemtoReg, PCSource, ALUSrcB, RegDst;
    logic [3:0] ALUOp, State;
    logic       ALUSrcA, RegWrite, Illegal;
`ifdef MC_PERF_CNT_EN
    logic [CW-1:0] CycleCount, RetireCount;
`endif

    multicycle_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .RegDst(RegDst),
        .State(State), .Illegal(Illegal)
`ifdef MC_PERF_CNT_EN
        , .CycleCount(CycleCount), .RetireCount(RetireCount)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: instruction-level state path plus per-state output table
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       pcw, iord, mrd, mwr, irw;
        logic [1:0] m2r, pcs;
        logic [3:0] aluop;
        logic       srca;
        logic [1:0] srcb;
        logic       rw;
        logic [1:0] rdst;
        logic       ill;
    } ctl_t;

    int exp_state = 0;
    int seq[$];
    logic [CW-1:0] exp_cyc = '0;
    logic [CW-1:0] exp_ret = '0;
    bit chk_en = 1'b0;

    function automatic ctl_t expect_ctl(int st, logic [5:0] op, logic z, logic mr, logic rst);
        ctl_t c;
        c = '0;
        case (st)
            0:  begin c.mrd = 1; c.srcb = 2'd1; c.irw = mr; c.pcw = mr; end
            1:  c.srcb = 2'd3;
            2:  begin c.srca = 1; c.srcb = 2'd2; end
            3:  begin c.iord = 1; c.mrd = 1; end
            4:  begin c.m2r = 2'd1; c.rw = 1; end
            5:  begin c.iord = 1; c.mwr = 1; end
            6:  begin c.srca = 1; c.aluop = 4'd7; end
            7:  begin c.rdst = 2'd1; c.rw = 1; end
            8:  begin c.srca = 1; c.aluop = 4'd1; c.pcs = 2'd1; c.pcw = (op == 6'h05) ? ~z : z; end
            9:  begin c.pcs = 2'd2; c.pcw = 1; end
            10: begin c.pcs = 2'd3; c.pcw = 1; end
            11: begin c.pcs = 2'd2; c.pcw = 1; c.rdst = 2'd2; c.m2r = 2'd2; c.rw = 1; end
            12: begin c.srca = 1; c.srcb = 2'd2; c.aluop = (op == 6'h0D) ? 4'd2 : 4'd0; end
            13: c.rw = 1;
            15: c.ill = 1;
            default: c.ill = 1;
        endcase
        if (rst) begin
            c.pcw = 0; c.mrd = 0; c.mwr = 0; c.irw = 0; c.rw = 0;
        end
        return c;
    endfunction

    always @(posedge clk) begin
        int prev;
        prev = exp_state;
        if (reset) begin
            exp_state = 0;
            seq.delete();
            exp_cyc = '0;
            exp_ret = '0;
        end else begin
            if (exp_state == 15) begin
                // stuck until reset
            end else if ((exp_state == 0 || exp_state == 3 || exp_state == 5) && !MemReady) begin
                // memory stall
            end else begin
                if (exp_state == 0) begin
                    case (OP)
                        6'h23: seq = '{1, 2, 3, 4};
                        6'h2B: seq = '{1, 2, 5};
                        6'h00: seq = (Funct == 6'h08) ? '{1, 10} : '{1, 6, 7};
                        6'h08, 6'h0D: seq = '{1, 12, 13};
                        6'h04, 6'h05: seq = '{1, 8};
                        6'h02: seq = '{1, 9};
                        6'h03: seq = '{1, 11};
                        default: seq = '{1, 15};
                    endcase
                end
                if (seq.size() == 0) exp_state = 0;
                else exp_state = seq.pop_front();
            end
            if (prev != 15) exp_cyc = exp_cyc + 1;
            if (prev != 0 && exp_state == 0) exp_ret = exp_ret + 1;
        end
    end

    // Per-cycle compare
    always @(negedge clk) begin
        if (chk_en) begin
            ctl_t act, exp;
            act = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, PCSource,
                   ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, Illegal};
            exp = expect_ctl(exp_state, OP, Zero, MemReady, reset);
            check("model_state", {28'd0, State}, exp_state);
            check("model_ctl", {12'd0, act}, {12'd0, exp});
`ifdef MC_PERF_CNT_EN
            check("model_cycles", CycleCount, exp_cyc);
            check("model_retire", RetireCount, exp_ret);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int lw_path[5] = '{0, 1, 2, 3, 4};
    logic [5:0] ops[10] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h0D, 6'h04, 6'h05, 6'h02, 6'h03, 6'h00};
    logic [5:0] fns[7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h08, 6'h08};

    initial begin
        int halt_cycles;
        reset = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;

        // 1: lw path 0,1,2,3,4 then back to FETCH
        reset = 1'b0; OP = 6'h23; MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("lw_state", State, lw_path[i]);
            if (i == 4) begin
                check("lw_wb_regwrite", RegWrite, 1);
                check("lw_wb_memtoreg", MemtoReg, 1);
                check("lw_wb_regdst", RegDst, 0);
            end else begin
                check("lw_no_regwrite", RegWrite, 0);
            end
            tick();
        end
        OP = 6'h02;
        MemReady = 1'b0;
        @(negedge clk);
        check("lw_back_fetch", State, 0);

        // 2: three FETCH stall cycles, then the handshake
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_state", State, 0);
            check("stall_pcwrite", PCWrite, 0);
            check("stall_irwrite", IRWrite, 0);
            tick();
        end
        MemReady = 1'b1;
        @(negedge clk);
        check("fetch_pcwrite", PCWrite, 1);
        check("fetch_irwrite", IRWrite, 1);
        tick();
        @(negedge clk);
        check("fetch_to_decode", State, 1);
        tick();
        @(negedge clk);
        check("jump_state", State, 9);
        check("jump_pcsource", PCSource, 2);
        tick();

        // 3: beq taken, then bne with Zero=1 and with Zero=0
        OP = 6'h04; Zero = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("beq_state", State, 8);
        check("beq_pcwrite", PCWrite, 1);
        check("beq_pcsource", PCSource, 1);
        tick();
        OP = 6'h05;
        tick(); tick();
        @(negedge clk);
        check("bne_z1_pcwrite", PCWrite, 0);
        #1 Zero = 1'b0;
        #1 check("bne_z0_pcwrite", PCWrite, 1);
        tick();

        // 4: jal then jr
        OP = 6'h03;
        tick(); tick();
        @(negedge clk);
        check("jal_state", State, 11);
        check("jal_outs", {RegDst, MemtoReg, RegWrite, PCWrite, PCSource}, {2'd2, 2'd2, 1'b1, 1'b1, 2'd2});
        tick();
        OP = 6'h00; Funct = 6'h08;
        tick(); tick();
        @(negedge clk);
        check("jr_state", State, 10);
        check("jr_regwrite", RegWrite, 0);
        check("jr_pcwrite_src", {PCWrite, PCSource}, {1'b1, 2'd3});
        tick();

        // 5: illegal opcode halts until reset
        OP = 6'h3F;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("halt_illegal", Illegal, 1);
            check("halt_enables", {PCWrite, MemRead, MemWrite, IRWrite, RegWrite}, 0);
            tick();
        end
        reset = 1'b1; OP = 6'h2B;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("halt_reset_state", State, 0);
        check("halt_reset_illegal", Illegal, 0);

        // 6: reset during a stalled MEM_WRITE
        tick(); tick();
        MemReady = 1'b0;
        tick();
        @(negedge clk);
        check("sw_state", State, 5);
        check("sw_memwrite", MemWrite, 1);
        reset = 1'b1;
        #1 check("sw_reset_memwrite", MemWrite, 0);
        tick();
        reset = 1'b0; MemReady = 1'b1; OP = 6'h08;
        @(negedge clk);
        check("sw_reset_state", State, 0);
`ifdef MC_PERF_CNT_EN
        check("sw_reset_cycles", CycleCount, 0);
        check("sw_reset_retire", RetireCount, 0);
`endif
        tick();

        // Randomized instruction stream
        halt_cycles = 0;
        for (int n = 0; n < 4000; n++) begin
            halt_cycles = (exp_state == 15) ? halt_cycles + 1 : 0;
            reset = (halt_cycles > 4) || ($urandom_range(0, 199) == 0);
            if (exp_state == 0) begin
                if ($urandom_range(0, 19) == 0) OP = 6'($urandom_range(0, 63));
                else OP = ops[$urandom_range(0, 9)];
                Funct = fns[$urandom_range(0, 6)];
            end
            Zero = 1'($urandom_range(0, 1));
            MemReady = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
